pool_window_scheduler: RTL and testbench

- Sequencer for the mean-pooling datapath.
- Walks a feature map stored in a single-port buffer in non-overlapping POOL_K x POOL_K windows and fetches each window's pixels.
- Presents each window as one packed neighborhood vector to the pooling unit, waits the pooling latency, then hands the pooled value downstream with its output address over a valid/ready handshake.
- Sits between the feature-map buffer and the next layer's input buffer.

---
 rtl/pool_window_scheduler_pkg.sv | 30 +++
 rtl/pool_addr_gen.sv | 92 +++++++++
 rtl/pool_window_scheduler.sv | 194 +++++++++++++++++++
 tb/tb_pool_window_scheduler.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pool_window_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// pool_window_scheduler_pkg
// Shared definitions for the mean-pooling window sequencer:
//   - DATA_W_DEF / POOL_K_DEF : default pixel width and window side
//   - NH_VEC_W                : packed neighbourhood width for the defaults
//   - state_t                 : sequencer state encoding
//   - clog2_min1()            : counter width helper that never returns 0
// -----------------------------------------------------------------------------
package pool_window_scheduler_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int POOL_K_DEF = 2;
    localparam int NH_VEC_W   = POOL_K_DEF * POOL_K_DEF * DATA_W_DEF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LAST,
        ST_ISSUE,
        ST_WAIT,
        ST_OUT,
        ST_DONE
    } state_t;

    // A counter over a range of 1 still needs one bit to exist.
    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/pool_addr_gen.sv
// -----------------------------------------------------------------------------
// pool_addr_gen
// Window walker for the pooling sequencer. Owns the in-window counters (kx inner,
// ky outer) and the window counters (wx inner, wy outer), and turns them into
// the buffer read address and the pooled-output address.
// Ports:
//   clock, reset             : clock, asynchronous active-high reset
//   clear                    : zero all counters (start of a pass)
//   step_inner               : advance kx/ky by one pixel
//   step_window              : advance wx/wy by one window
//   last_inner               : kx/ky point at the last pixel of the window
//   last_window              : wx/wy point at the last window of the map
//   slot                     : neighbourhood slot ky*POOL_K+kx of the current pixel
//   rd_addr                  : (wy*POOL_K+ky)*FM_W + wx*POOL_K + kx
//   out_addr                 : wy*(FM_W/POOL_K) + wx
// -----------------------------------------------------------------------------
module pool_addr_gen
    import pool_window_scheduler_pkg::*;
#(
    parameter int FM_W   = 8,
    parameter int FM_H   = 8,
    parameter int POOL_K = POOL_K_DEF,
    parameter int ADDR_W = 12,
    parameter int SLOT_W = clog2_min1(POOL_K * POOL_K)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              step_inner,
    input  logic              step_window,
    output logic              last_inner,
    output logic              last_window,
    output logic [SLOT_W-1:0] slot,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W-1:0] out_addr
);

    localparam int WIN_X = FM_W / POOL_K;
    localparam int WIN_Y = FM_H / POOL_K;
    localparam int KW    = clog2_min1(POOL_K);
    localparam int WXW   = clog2_min1(WIN_X);
    localparam int WYW   = clog2_min1(WIN_Y);

    localparam logic [KW-1:0]  K_MAX  = KW'(POOL_K - 1);
    localparam logic [WXW-1:0] WX_MAX = WXW'(WIN_X - 1);
    localparam logic [WYW-1:0] WY_MAX = WYW'(WIN_Y - 1);

    logic [KW-1:0]  kx, ky;
    logic [WXW-1:0] wx;
    logic [WYW-1:0] wy;

    // NOTE: state registers use non-blocking assignments and reset asynchronously
    // so every counter updates from the same pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            kx <= '0;
            ky <= '0;
            wx <= '0;
            wy <= '0;
        end else if (clear) begin
            kx <= '0;
            ky <= '0;
            wx <= '0;
            wy <= '0;
        end else begin
            if (step_inner) begin
                if (kx == K_MAX) begin
                    kx <= '0;
                    ky <= (ky == K_MAX) ? '0 : ky + 1'b1;
                end else begin
                    kx <= kx + 1'b1;
                end
            end
            if (step_window) begin
                if (wx == WX_MAX) begin
                    wx <= '0;
                    wy <= (wy == WY_MAX) ? '0 : wy + 1'b1;
                end else begin
                    wx <= wx + 1'b1;
                end
            end
        end
    end

    assign last_inner  = (kx == K_MAX) && (ky == K_MAX);
    assign last_window = (wx == WX_MAX) && (wy == WY_MAX);

    assign slot     = SLOT_W'(32'(ky) * POOL_K + 32'(kx));
    assign rd_addr  = ADDR_W'((32'(wy) * POOL_K + 32'(ky)) * FM_W + 32'(wx) * POOL_K + 32'(kx));
    assign out_addr = ADDR_W'(32'(wy) * WIN_X + 32'(wx));

endmodule

// File: rtl/pool_window_scheduler.sv
// -----------------------------------------------------------------------------
// pool_window_scheduler
// Sequencer for the mean-pooling datapath. Walks a feature map held in a
// single-port buffer in non-overlapping POOL_K x POOL_K windows, gathers each
// window into one packed neighbourhood vector for the pooling unit, waits
// POOL_LAT cycles, and hands the pooled value downstream over valid/ready.
// Optional build macro: POOL_SCHED_PERF_EN adds stall_cycles / window_count.
// Ports:
//   clock, reset        : clock, asynchronous active-high reset
//   start               : pulse to begin a full-map pass (ignored unless idle)
//   busy, done          : pass in progress / one-cycle completion pulse
//   rd_en, rd_addr      : buffer read request (data returns one cycle later)
//   rd_data             : buffer read data
//   nh_vector, nh_valid : packed window (slot s at [s*DATA_W +: DATA_W]) + strobe
//   pool_result         : pooled value from the pooling unit
//   out_data, out_addr  : captured pooled value and its output index
//   out_valid, out_ready: downstream handshake
//   stall_cycles        : (perf) cycles in OUT without out_ready, saturating
//   window_count        : (perf) accepted outputs, saturating
// -----------------------------------------------------------------------------
module pool_window_scheduler
    import pool_window_scheduler_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int FM_W     = 8,
    parameter int FM_H     = 8,
    parameter int POOL_K   = POOL_K_DEF,
    parameter int ADDR_W   = 12,
    parameter int POOL_LAT = 1
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              start,
    output logic                              busy,
    output logic                              done,
    output logic                              rd_en,
    output logic [ADDR_W-1:0]                 rd_addr,
    input  logic [DATA_W-1:0]                 rd_data,
    output logic [POOL_K*POOL_K*DATA_W-1:0]   nh_vector,
    output logic                              nh_valid,
    input  logic [DATA_W-1:0]                 pool_result,
    output logic [DATA_W-1:0]                 out_data,
    output logic [ADDR_W-1:0]                 out_addr,
    output logic                              out_valid,
    input  logic                              out_ready
`ifdef POOL_SCHED_PERF_EN
   ,output logic [31:0]                       stall_cycles,
    output logic [15:0]                       window_count
`endif
);

    localparam int          SLOT_W   = clog2_min1(POOL_K * POOL_K);
    localparam int          VEC_W    = POOL_K * POOL_K * DATA_W;
    localparam logic [3:0]  LAT_LAST = 4'((POOL_LAT > 0) ? POOL_LAT - 1 : 0);

    state_t              state_q, state_d;
    logic [3:0]          lat_cnt_q;
    logic                rd_en_q;
    logic [SLOT_W-1:0]   slot_q;
    logic [VEC_W-1:0]    nh_vec_q;
    logic [DATA_W-1:0]   out_data_q;

    logic                step_inner, step_window, clear_cnt, capture, accept_start;
    logic                last_inner, last_window;
    logic [SLOT_W-1:0]   slot;

    pool_addr_gen #(
        .FM_W   (FM_W),
        .FM_H   (FM_H),
        .POOL_K (POOL_K),
        .ADDR_W (ADDR_W),
        .SLOT_W (SLOT_W)
    ) u_addr_gen (
        .clock       (clock),
        .reset       (reset),
        .clear       (clear_cnt),
        .step_inner  (step_inner),
        .step_window (step_window),
        .last_inner  (last_inner),
        .last_window (last_window),
        .slot        (slot),
        .rd_addr     (rd_addr),
        .out_addr    (out_addr)
    );

    // NOTE: every signal driven here gets a default before the case statement,
    // so no path through the block can leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        busy         = 1'b1;
        done         = 1'b0;
        rd_en        = 1'b0;
        nh_valid     = 1'b0;
        out_valid    = 1'b0;
        step_inner   = 1'b0;
        step_window  = 1'b0;
        clear_cnt    = 1'b0;
        capture      = 1'b0;
        accept_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    accept_start = 1'b1;
                    clear_cnt    = 1'b1;
                    state_d      = ST_FETCH;
                end
            end
            ST_FETCH: begin
                rd_en      = 1'b1;
                step_inner = 1'b1;
                if (last_inner) state_d = ST_LAST;
            end
            // The final read's data arrives here and is written at the end of
            // this cycle, so the vector is complete by ISSUE.
            ST_LAST: state_d = ST_ISSUE;
            ST_ISSUE: begin
                nh_valid = 1'b1;
                if (POOL_LAT == 0) begin
                    capture = 1'b1;
                    state_d = ST_OUT;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (lat_cnt_q == LAT_LAST) begin
                    capture = 1'b1;
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    step_window = 1'b1;
                    state_d     = last_window ? ST_DONE : ST_FETCH;
                end
            end
            ST_DONE: begin
                busy    = 1'b0;
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: nh_vector is a register array, but it is reset along with the rest
    // of the state because it is a visible output that must read 0 after reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            lat_cnt_q  <= '0;
            rd_en_q    <= 1'b0;
            slot_q     <= '0;
            nh_vec_q   <= '0;
            out_data_q <= '0;
        end else begin
            state_q <= state_d;
            // Registered request tag: the buffer answers one cycle after rd_en,
            // when the live slot counter has already moved on.
            rd_en_q <= rd_en;
            slot_q  <= slot;
            if (rd_en_q) nh_vec_q[slot_q*DATA_W +: DATA_W] <= rd_data;
            if (capture) out_data_q <= pool_result;
            if (state_q == ST_ISSUE)     lat_cnt_q <= '0;
            else if (state_q == ST_WAIT) lat_cnt_q <= lat_cnt_q + 1'b1;
        end
    end

    assign nh_vector = nh_vec_q;
    assign out_data  = out_data_q;

`ifdef POOL_SCHED_PERF_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
            window_count <= '0;
        end else if (accept_start) begin
            stall_cycles <= '0;
            window_count <= '0;
        end else begin
            if (state_q == ST_OUT && !out_ready && stall_cycles != '1)
                stall_cycles <= stall_cycles + 1'b1;
            if (step_window && window_count != '1)
                window_count <= window_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pool_window_scheduler.sv
// -----------------------------------------------------------------------------
// tb_pool_window_scheduler
// Directed bench: a 4x4 map with POOL_LAT=1 and a mean-pooling model, plus two
// 4x2 instances with POOL_LAT=0 and POOL_LAT=3 whose pooling unit returns the
// cycle number, so the captured value shows exactly when it was sampled.
// -----------------------------------------------------------------------------
module tb_pool_window_scheduler;

    logic        clock;
    logic        reset;
    int          cyc;
    int          n_chk;
    int          n_err;

    // Main instance: 4x4 map, POOL_LAT=1
    logic        start, busy, done, rd_en, nh_valid, out_valid, out_ready;
    logic [11:0] rd_addr, out_addr;
    logic [7:0]  rd_data, pool_result, out_data;
    logic [31:0] nh_vector;

    // Latency variants: 4x2 map
    logic        start_v0, busy_v0, done_v0, rd_en_v0, nh_valid_v0, out_valid_v0;
    logic [11:0] rd_addr_v0, out_addr_v0;
    logic [7:0]  rd_data_v0, out_data_v0;
    logic [31:0] nh_vector_v0;
    logic        start_v3, busy_v3, done_v3, rd_en_v3, nh_valid_v3, out_valid_v3;
    logic [11:0] rd_addr_v3, out_addr_v3;
    logic [7:0]  rd_data_v3, out_data_v3;
    logic [31:0] nh_vector_v3;
    logic [7:0]  pool_cyc;

`ifdef POOL_SCHED_PERF_EN
    logic [31:0] stall_cycles, stall_cycles_v0, stall_cycles_v3;
    logic [15:0] window_count, window_count_v0, window_count_v3;
`endif

    pool_window_scheduler #(
        .DATA_W(8), .FM_W(4), .FM_H(4), .POOL_K(2), .ADDR_W(12), .POOL_LAT(1)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .nh_vector(nh_vector), .nh_valid(nh_valid), .pool_result(pool_result),
        .out_data(out_data), .out_addr(out_addr), .out_valid(out_valid),
        .out_ready(out_ready)
`ifdef POOL_SCHED_PERF_EN
       ,.stall_cycles(stall_cycles), .window_count(window_count)
`endif
    );

    pool_window_scheduler #(
        .DATA_W(8), .FM_W(4), .FM_H(2), .POOL_K(2), .ADDR_W(12), .POOL_LAT(0)
    ) dut_lat0 (
        .clock(clock), .reset(reset), .start(start_v0), .busy(busy_v0), .done(done_v0),
        .rd_en(rd_en_v0), .rd_addr(rd_addr_v0), .rd_data(rd_data_v0),
        .nh_vector(nh_vector_v0), .nh_valid(nh_valid_v0), .pool_result(pool_cyc),
        .out_data(out_data_v0), .out_addr(out_addr_v0), .out_valid(out_valid_v0),
        .out_ready(1'b1)
`ifdef POOL_SCHED_PERF_EN
       ,.stall_cycles(stall_cycles_v0), .window_count(window_count_v0)
`endif
    );

    pool_window_scheduler #(
        .DATA_W(8), .FM_W(4), .FM_H(2), .POOL_K(2), .ADDR_W(12), .POOL_LAT(3)
    ) dut_lat3 (
        .clock(clock), .reset(reset), .start(start_v3), .busy(busy_v3), .done(done_v3),
        .rd_en(rd_en_v3), .rd_addr(rd_addr_v3), .rd_data(rd_data_v3),
        .nh_vector(nh_vector_v3), .nh_valid(nh_valid_v3), .pool_result(pool_cyc),
        .out_data(out_data_v3), .out_addr(out_addr_v3), .out_valid(out_valid_v3),
        .out_ready(1'b1)
`ifdef POOL_SCHED_PERF_EN
       ,.stall_cycles(stall_cycles_v3), .window_count(window_count_v3)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Free-running cycle number; also the "pooled value" of the latency variants.
    always @(posedge clock) cyc <= cyc + 1;
    assign pool_cyc = cyc[7:0];

    // Buffer model: location a holds a, one-cycle read latency.
    always @(posedge clock) if (rd_en)    rd_data    <= rd_addr[7:0];
    always @(posedge clock) if (rd_en_v0) rd_data_v0 <= rd_addr_v0[7:0];
    always @(posedge clock) if (rd_en_v3) rd_data_v3 <= rd_addr_v3[7:0];

    // Pooling unit model with one cycle of latency: integer mean of 4 slots.
    function automatic logic [7:0] mean4(input logic [31:0] v);
        logic [9:0] s;
        s = 10'(v[7:0]) + 10'(v[15:8]) + 10'(v[23:16]) + 10'(v[31:24]);
        return s[9:2];
    endfunction
    always @(posedge clock) pool_result <= mean4(nh_vector);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_out(input int budget);
        int n = 0;
        do begin @(negedge clock); n++; end while (out_valid !== 1'b1 && n < budget);
    endtask

    task automatic wait_nh(input int budget);
        int n = 0;
        do begin @(negedge clock); n++; end while (nh_valid !== 1'b1 && n < budget);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        do begin @(negedge clock); n++; end while (done !== 1'b1 && n < budget);
    endtask

    task automatic pulse_start();
        @(negedge clock) start = 1'b1;
        @(negedge clock) start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int f;
        int exp_d [4];
        int iss [2];
        int od [2];
        int oa [2];
        int ni, no, nd;

        exp_d = '{2, 4, 10, 12};
        n_chk = 0; n_err = 0; cyc = 0;
        reset = 1'b1; start = 1'b0; out_ready = 1'b1;
        start_v0 = 1'b0; start_v3 = 1'b0;

        // ---------------- reset state ----------------
        repeat (2) @(negedge clock);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_nh_valid", nh_valid, 0);
        check("rst_nh_vector", nh_vector, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_addr", out_addr, 0);
        reset = 1'b0;

        // ---------------- pass 1: first window, full pass ----------------
        pulse_start();
        f = cyc;
        check("p1_busy", busy, 1);
        check("p1_rd_en0", rd_en, 1);
        check("p1_rd_addr0", rd_addr, 0);
        @(negedge clock) check("p1_rd_addr1", rd_addr, 1);
        @(negedge clock) check("p1_rd_addr2", rd_addr, 4);
        @(negedge clock) check("p1_rd_addr3", rd_addr, 5);
        @(negedge clock) check("p1_last_rd_en", rd_en, 0);
        check("p1_last_nh_valid", nh_valid, 0);
        @(negedge clock);
        check("p1_issue_nh_valid", nh_valid, 1);
        check("p1_issue_vector", nh_vector, 32'h05040100);
        start = 1'b1;                       // ignored: already busy
        @(negedge clock);
        start = 1'b0;
        check("p1_nh_valid_one_cycle", nh_valid, 0);
        check("p1_wait_busy", busy, 1);
        @(negedge clock);
        check("p1_w0_out_valid", out_valid, 1);
        check("p1_w0_out_addr", out_addr, 0);
        check("p1_w0_out_data", out_data, exp_d[0]);
        for (int w = 1; w < 4; w++) begin
            wait_out(20);
            check("p1_out_valid", out_valid, 1);
            check("p1_out_addr", out_addr, w);
            check("p1_out_data", out_data, exp_d[w]);
        end
        wait_done(20);
        check("p1_done", done, 1);
        check("p1_done_time", cyc - f, 32);
        check("p1_busy_at_done", busy, 0);
        start = 1'b1;                       // ignored: DONE cycle
        @(negedge clock);
        start = 1'b0;
        check("p1_no_restart_busy", busy, 0);
        check("p1_done_one_cycle", done, 0);
        @(negedge clock);
        check("p1_no_restart_rd_en", rd_en, 0);
        check("p1_idle_busy", busy, 0);

        // ---------------- pass 2: back-pressure on window 1 ----------------
        pulse_start();
        wait_out(20);
        check("p2_w0_out_addr", out_addr, 0);
        @(negedge clock) out_ready = 1'b0;
        wait_out(20);
        check("p2_w1_out_valid", out_valid, 1);
        check("p2_w1_out_addr", out_addr, 1);
        check("p2_w1_out_data", out_data, 4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("p2_hold_valid", out_valid, 1);
            check("p2_hold_addr", out_addr, 1);
            check("p2_hold_data", out_data, 4);
            check("p2_hold_no_rd", rd_en, 0);
        end
        out_ready = 1'b1;
        @(negedge clock);
        check("p2_released", out_valid, 0);
`ifdef POOL_SCHED_PERF_EN
        check("p2_stall_cycles", stall_cycles, 5);
        check("p2_window_count", window_count, 2);
`endif
        wait_out(20);
        check("p2_w2_out_addr", out_addr, 2);
        check("p2_w2_out_data", out_data, 10);
        wait_out(20);
        check("p2_w3_out_addr", out_addr, 3);
        check("p2_w3_out_data", out_data, 12);
        wait_done(20);
        check("p2_done", done, 1);

        // ---------------- pass 3: reset during WAIT of window 2 ----------------
        pulse_start();
        wait_nh(20);
        wait_nh(20);
        wait_nh(20);
        check("p3_w2_issue", nh_valid, 1);
        @(negedge clock);
        check("p3_in_wait", busy, 1);
        reset = 1'b1;
        #1;
        check("p3_rst_busy", busy, 0);
        check("p3_rst_rd_en", rd_en, 0);
        check("p3_rst_rd_addr", rd_addr, 0);
        check("p3_rst_nh_vector", nh_vector, 0);
        check("p3_rst_out_valid", out_valid, 0);
        check("p3_rst_out_data", out_data, 0);
        check("p3_rst_out_addr", out_addr, 0);
        check("p3_rst_done", done, 0);
        @(negedge clock) reset = 1'b0;
        pulse_start();
        check("p3_restart_rd_en", rd_en, 1);
        check("p3_restart_rd_addr", rd_addr, 0);
        wait_out(20);
        check("p3_w0_out_addr", out_addr, 0);
        check("p3_w0_out_data", out_data, 2);
        wait_done(64);
        check("p3_done", done, 1);

        // ---------------- latency variant POOL_LAT=0 ----------------
        ni = 0; no = 0; nd = 0;
        @(negedge clock) start_v0 = 1'b1;
        @(negedge clock) start_v0 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (nh_valid_v0 && ni < 2) begin iss[ni] = cyc; ni++; end
            if (out_valid_v0 && no < 2) begin od[no] = int'(out_data_v0); oa[no] = int'(out_addr_v0); no++; end
            if (done_v0) nd++;
            @(negedge clock);
        end
        check("lat0_issues", ni, 2);
        check("lat0_outputs", no, 2);
        check("lat0_data0", od[0], iss[0] & 8'hff);
        check("lat0_data1", od[1], iss[1] & 8'hff);
        check("lat0_addr1", oa[1], 1);
        check("lat0_period", iss[1] - iss[0], 7);
        check("lat0_done_count", nd, 1);
        check("lat0_idle", busy_v0, 0);
        check("lat0_vector", nh_vector_v0, 32'h07060302);
`ifdef POOL_SCHED_PERF_EN
        check("lat0_window_count", window_count_v0, 2);
        check("lat0_stall_cycles", stall_cycles_v0, 0);
`endif

        // ---------------- latency variant POOL_LAT=3 ----------------
        ni = 0; no = 0; nd = 0;
        @(negedge clock) start_v3 = 1'b1;
        @(negedge clock) start_v3 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (nh_valid_v3 && ni < 2) begin iss[ni] = cyc; ni++; end
            if (out_valid_v3 && no < 2) begin od[no] = int'(out_data_v3); oa[no] = int'(out_addr_v3); no++; end
            if (done_v3) nd++;
            @(negedge clock);
        end
        check("lat3_issues", ni, 2);
        check("lat3_outputs", no, 2);
        check("lat3_data0", od[0], (iss[0] + 3) & 8'hff);
        check("lat3_data1", od[1], (iss[1] + 3) & 8'hff);
        check("lat3_addr1", oa[1], 1);
        check("lat3_period", iss[1] - iss[0], 10);
        check("lat3_done_count", nd, 1);
        check("lat3_idle", busy_v3, 0);
        check("lat3_vector", nh_vector_v3, 32'h07060302);
`ifdef POOL_SCHED_PERF_EN
        check("lat3_window_count", window_count_v3, 2);
        check("lat3_stall_cycles", stall_cycles_v3, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
